// File: rtl/crosshair_tracker_pkg.sv
// Shared types and default widths for the crosshair tracker.
package tracker_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIV_X  = 2'd1,
        DIV_Y  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam int unsigned HW       = 11;
    localparam int unsigned VW       = 10;
    localparam int unsigned DEF_SUMW = 32;
    localparam int unsigned DEF_CNTW = 20;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; the start cycle already retires the first bit,
// so done is raised DW cycles after start. A zero divisor yields quotient 0.
module seq_divider #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          done
);

    localparam int unsigned CW = $clog2(DW);

    logic [DW-1:0] rem, quo, dsr;
    logic [DW-1:0] src_rem, src_quo, src_dsr;
    logic [DW-1:0] nxt_rem, nxt_quo;
    logic [DW:0]   shifted;
    logic [CW-1:0] cnt;
    logic          active;
    logic          div_zero;

    always_comb begin
        src_rem = start ? '0 : rem;
        src_quo = start ? dividend : quo;
        src_dsr = start ? divisor : dsr;
        shifted = {src_rem, src_quo[DW-1]};
        nxt_quo = {src_quo[DW-2:0], 1'b0};
        nxt_rem = shifted[DW-1:0];
        if (shifted >= {1'b0, src_dsr}) begin
            nxt_rem    = DW'(shifted - {1'b0, src_dsr});
            nxt_quo[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            rem      <= nxt_rem;
            quo      <= nxt_quo;
            dsr      <= divisor;
            cnt      <= CW'(DW - 1);
            active   <= 1'b1;
            div_zero <= (divisor == '0);
        end else if (active) begin
            if (cnt != '0) begin
                rem <= nxt_rem;
                quo <= nxt_quo;
                cnt <= cnt - CW'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign done     = active && (cnt == '0);
    assign quotient = div_zero ? '0 : quo;

endmodule

// File: rtl/crosshair_tracker.sv
// Per-frame mask centroid tracker driving the crosshair overlay bit.
// Optional: TRACKER_SMOOTH_EN enables 3:1 exponential smoothing of the centroid.
module crosshair_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 1280,
    parameter int unsigned V_ACTIVE  = 720,
    parameter int unsigned MIN_COUNT = 16,
    parameter int unsigned SUMW      = DEF_SUMW,
    parameter int unsigned CNTW      = DEF_CNTW
) (
    input  logic          clk_pixel_in,
    input  logic          rst_n_in,
    input  logic [HW-1:0] hcount_in,
    input  logic [VW-1:0] vcount_in,
    input  logic          data_valid_in,
    input  logic          mask_in,
    input  logic          frame_done_in,
    output logic [HW-1:0] x_out,
    output logic [VW-1:0] y_out,
    output logic          valid_out,
    output logic          busy_out,
    output logic          crosshair_out
);

    localparam logic [HW-1:0] H_LIM = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LIM = VW'(V_ACTIVE);

    state_t state, state_nxt;

    logic [SUMW-1:0] sum_x, sum_y, snap_y;
    logic [CNTW-1:0] count, snap_cnt;
    logic [HW-1:0]   qx;
    logic [VW-1:0]   qy;
    logic            in_active, pix_hit, take;
    logic            div_start, div_done;
    logic [SUMW-1:0] div_dividend, div_divisor, div_quotient;
    logic            unused_quotient_bits;

    assign in_active = (hcount_in < H_LIM) && (vcount_in < V_LIM);
    assign pix_hit   = data_valid_in && mask_in && in_active;
    assign take      = (state == ACCUM) && frame_done_in;
    assign busy_out  = (state != ACCUM);
    assign qy        = div_quotient[VW-1:0];
    assign unused_quotient_bits = ^div_quotient[SUMW-1:HW];

    // X is started straight from the live sums in the frame_done cycle (same values the
    // snapshot captures), so each divide occupies exactly SUMW cycles of its state.
    always_comb begin
        state_nxt    = state;
        div_start    = 1'b0;
        div_dividend = sum_x;
        div_divisor  = SUMW'(count);
        case (state)
            ACCUM: begin
                if (frame_done_in) begin
                    div_start = 1'b1;
                    state_nxt = DIV_X;
                end
            end
            DIV_X: begin
                div_dividend = snap_y;
                div_divisor  = SUMW'(snap_cnt);
                if (div_done) begin
                    div_start = 1'b1;
                    state_nxt = DIV_Y;
                end
            end
            DIV_Y: begin
                div_dividend = snap_y;
                div_divisor  = SUMW'(snap_cnt);
                if (div_done) state_nxt = UPDATE;
            end
            UPDATE:  state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    seq_divider #(.DW(SUMW)) u_div (
        .clk      (clk_pixel_in),
        .rst_n    (rst_n_in),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

`ifdef TRACKER_SMOOTH_EN
    logic [HW+1:0] smooth_x;
    logic [VW+1:0] smooth_y;

    always_comb begin
        smooth_x = {2'b00, x_out} + {1'b0, x_out, 1'b0} + {2'b00, qx};
        smooth_y = {2'b00, y_out} + {1'b0, y_out, 1'b0} + {2'b00, qy};
    end
`endif

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= ACCUM;
            sum_x         <= '0;
            sum_y         <= '0;
            count         <= '0;
            snap_y        <= '0;
            snap_cnt      <= '0;
            qx            <= '0;
            x_out         <= '0;
            y_out         <= '0;
            valid_out     <= 1'b0;
            crosshair_out <= 1'b0;
        end else begin
            state <= state_nxt;

            if (take) begin
                snap_y   <= sum_y;
                snap_cnt <= count;
                sum_x    <= pix_hit ? SUMW'(hcount_in) : '0;
                sum_y    <= pix_hit ? SUMW'(vcount_in) : '0;
                count    <= pix_hit ? CNTW'(1) : '0;
            end else if (pix_hit) begin
                sum_x <= sum_x + SUMW'(hcount_in);
                sum_y <= sum_y + SUMW'(vcount_in);
                count <= count + CNTW'(1);
            end

            if (state == DIV_X && div_done) qx <= div_quotient[HW-1:0];

            if (state == UPDATE) begin
                if (snap_cnt >= CNTW'(MIN_COUNT)) begin
`ifdef TRACKER_SMOOTH_EN
                    if (valid_out) begin
                        x_out <= smooth_x[HW+1:2];
                        y_out <= smooth_y[VW+1:2];
                    end else begin
                        x_out <= qx;
                        y_out <= qy;
                    end
`else
                    x_out <= qx;
                    y_out <= qy;
`endif
                    valid_out <= 1'b1;
                end else begin
                    valid_out <= 1'b0;
                end
            end

            crosshair_out <= valid_out && data_valid_in && in_active &&
                             ((hcount_in == x_out) || (vcount_in == y_out));
        end
    end

endmodule

// File: tb/tb_crosshair_tracker.sv
// Directed self-checking bench for crosshair_tracker (default build; smoothing value guarded).
module tb_crosshair_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        dv, mask, fd;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out, busy_out, crosshair_out;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    crosshair_tracker #(
        .H_ACTIVE  (1280),
        .V_ACTIVE  (720),
        .MIN_COUNT (16),
        .SUMW      (32),
        .CNTW      (20)
    ) dut (
        .clk_pixel_in  (clk),
        .rst_n_in      (rst_n),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .data_valid_in (dv),
        .mask_in       (mask),
        .frame_done_in (fd),
        .x_out         (x_out),
        .y_out         (y_out),
        .valid_out     (valid_out),
        .busy_out      (busy_out),
        .crosshair_out (crosshair_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // one cycle of inputs, applied on the falling edge
    task automatic drive(input logic v, input logic m, input int h, input int r, input logic f);
        @(negedge clk);
        dv = v; mask = m; hcount = 11'(h); vcount = 10'(r); fd = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic pixels(input int n, input int h, input int r);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, h, r, 1'b0);
    endtask

    // frame_done, then wait until the first cycle the result is visible
    task automatic end_frame();
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        idle(66);
    endtask

    task automatic cross_px(input string tag, input logic v, input int h, input int r,
                            input logic exp);
        drive(v, 1'b0, h, r, 1'b0);
        @(posedge clk);
        #1 check(tag, 32'(crosshair_out), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; dv = 1'b0; mask = 1'b0; fd = 1'b0; hcount = '0; vcount = '0;
        repeat (3) @(negedge clk);
        check("rst_x", 32'(x_out), 0);
        check("rst_y", 32'(y_out), 0);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_cross", 32'(crosshair_out), 0);
        rst_n = 1'b1;
        idle(2);

        // 4x4 block, cols 100..103 rows 200..203, with exact latency check
        for (int r = 200; r < 204; r++)
            for (int h = 100; h < 104; h++) pixels(1, h, r);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        idle(1);
        check("busy_in_div", 32'(busy_out), 1);
        idle(64);
        check("lat_not_yet_valid", 32'(valid_out), 0);
        check("lat_busy_update", 32'(busy_out), 1);
        idle(1);
        check("blk_x", 32'(x_out), 101);
        check("blk_y", 32'(y_out), 201);
        check("blk_valid", 32'(valid_out), 1);
        check("blk_busy_done", 32'(busy_out), 0);

        // crosshair sweep
        for (int h = 99; h < 104; h++) cross_px("sweep_col", 1'b1, h, 150, 1'(h == 101));
        cross_px("row_h0", 1'b1, 0, 201, 1'b1);
        cross_px("row_h500", 1'b1, 500, 201, 1'b1);
        cross_px("row_hblank", 1'b1, 1280, 201, 1'b0);
        cross_px("col_vblank", 1'b1, 101, 720, 1'b0);
        cross_px("no_valid", 1'b0, 101, 201, 1'b0);

        // empty frame holds position
        end_frame();
        check("empty_valid", 32'(valid_out), 0);
        check("empty_x_hold", 32'(x_out), 101);
        check("empty_y_hold", 32'(y_out), 201);
        cross_px("empty_cross", 1'b1, 101, 201, 1'b0);

        // 15 pixels plus pixels that must not count
        pixels(15, 5, 5);
        drive(1'b1, 1'b1, 1280, 5, 1'b0);
        drive(1'b1, 1'b1, 5, 720, 1'b0);
        drive(1'b0, 1'b1, 5, 5, 1'b0);
        end_frame();
        check("min15_valid", 32'(valid_out), 0);
        check("min15_x_hold", 32'(x_out), 101);
        pixels(16, 10, 10);
        end_frame();
        check("min16_x", 32'(x_out), 10);
        check("min16_y", 32'(y_out), 10);
        check("min16_valid", 32'(valid_out), 1);

        // frame_done during DIV_X is ignored; pixels merge into next result
        pixels(16, 20, 30);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        idle(1);
        pixels(8, 40, 50);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        idle(1);
        check("ign_busy", 32'(busy_out), 1);
        idle(55);
        check("ign_x", 32'(x_out), 20);
        check("ign_y", 32'(y_out), 30);
        pixels(8, 60, 70);
        end_frame();
        check("merge_x", 32'(x_out), 50);
        check("merge_y", 32'(y_out), 60);
        check("merge_valid", 32'(valid_out), 1);

        // reset during DIV_Y
        pixels(16, 300, 400);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        idle(40);
        check("pre_rst_busy", 32'(busy_out), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_x", 32'(x_out), 0);
        check("mid_rst_y", 32'(y_out), 0);
        check("mid_rst_valid", 32'(valid_out), 0);
        check("mid_rst_busy", 32'(busy_out), 0);
        idle(2);
        rst_n = 1'b1;
        idle(40);
        check("post_rst_valid", 32'(valid_out), 0);
        check("post_rst_x", 32'(x_out), 0);

        // two valid frames back to back
        pixels(16, 100, 100);
        end_frame();
        check("seq1_x", 32'(x_out), 100);
        pixels(16, 200, 200);
        end_frame();
`ifdef TRACKER_SMOOTH_EN
        check("seq2_x", 32'(x_out), 125);
        check("seq2_y", 32'(y_out), 125);
`else
        check("seq2_x", 32'(x_out), 200);
        check("seq2_y", 32'(y_out), 200);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
